// File: rtl/fmul_pipe_ctrl_if.sv
// Handshake bundle between the requesters/consumer and the multiplier pipeline controller.
// master = environment side (requesters + consumer), slave = the controller.
interface fmul_pipe_ctrl_if;
    logic req0_valid;
    logic req0_ready;
    logic req1_valid;
    logic req1_ready;
    logic issue_sel;
    logic s1_en;
    logic s2_en;
    logic s3_en;
    logic out_valid;
    logic out_tag;
    logic out_ready;
    logic busy;

    modport master (
        output req0_valid, req1_valid, out_ready,
        input  req0_ready, req1_ready, issue_sel, s1_en, s2_en, s3_en,
               out_valid, out_tag, busy
    );

    modport slave (
        input  req0_valid, req1_valid, out_ready,
        output req0_ready, req1_ready, issue_sel, s1_en, s2_en, s3_en,
               out_valid, out_tag, busy
    );
endinterface

// File: rtl/fmul_pipe_ctrl.sv
// Control for a 3-stage floating-point multiplier: round-robin issue of two requesters,
// bubble-collapsing stage enables. Optional perf counters under `FMUL_CTRL_PERF_EN.
module fmul_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fmul_pipe_ctrl_if.slave     bus
`ifdef FMUL_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    perf_issue_cnt,
    output logic [CNT_W-1:0]    perf_stall_cnt
`endif
);

    logic v1, v2, v3;
    logic t1, t2, t3;
    logic lg;
    logic grant;
    logic any_req;
    logic issue;
    logic s1_en, s2_en, s3_en;

    // A stage may load whenever it is empty or its contents move on this cycle.
    assign s3_en = !v3 | bus.out_ready;
    assign s2_en = !v2 | s3_en;
    assign s1_en = !v1 | s2_en;

    assign any_req = bus.req0_valid | bus.req1_valid;
    assign issue   = any_req & s1_en;

    // With no request the grant idles on lg, so issue_sel holds the last winner.
    always_comb begin
        grant = lg;
        if (bus.req0_valid && bus.req1_valid) grant = ~lg;
        else if (bus.req1_valid)              grant = 1'b1;
        else if (bus.req0_valid)              grant = 1'b0;
    end

    assign bus.s1_en      = s1_en;
    assign bus.s2_en      = s2_en;
    assign bus.s3_en      = s3_en;
    assign bus.issue_sel  = grant;
    assign bus.req0_ready = s1_en & !grant;
    assign bus.req1_ready = s1_en &  grant;
    assign bus.out_valid  = rst_n & v3;
    assign bus.out_tag    = t3;
    assign bus.busy       = rst_n & (v1 | v2 | v3);

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            t1 <= 1'b0;
            t2 <= 1'b0;
            t3 <= 1'b0;
            lg <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each stage read its predecessor's pre-edge value.
            if (s3_en) begin
                v3 <= v2;
                t3 <= t2;
            end
            if (s2_en) begin
                v2 <= v1;
                t2 <= t1;
            end
            if (s1_en) begin
                v1 <= issue;
                t1 <= grant;
            end
            if (issue) lg <= grant;
        end
    end

`ifdef FMUL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_issue_cnt != {CNT_W{1'b1}})
                perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
            if (v3 && !bus.out_ready && perf_stall_cnt != {CNT_W{1'b1}})
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fmul_pipe_ctrl.sv
// Self-checking bench for fmul_pipe_ctrl: directed scenarios plus random traffic,
// compared each cycle against a slot/queue model of the pipeline.
module tb_fmul_pipe_ctrl;

`ifdef FMUL_CTRL_PERF_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] perf_issue_cnt;
    logic [CNT_W-1:0] perf_stall_cnt;
`else
    localparam int CNT_W = 16;
`endif
    localparam int SAT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmul_pipe_ctrl_if bus ();

    fmul_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef FMUL_CTRL_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: occupancy of the three stages plus an in-order queue of the
    // requester ids of the entries in flight (oldest first = stage 3).
    bit m_v[1:3];
    bit m_lg;
    int tag_q[$];
    int m_issues;
    int m_stalls;
    int grant_log[$];
    bit go1, go2, go3;
    int m_grant;

    function automatic int pick(bit r0, bit r1, bit last);
        if (r0 && r1) return (last == 1'b0) ? 1 : 0;
        if (r1)       return 1;
        if (r0)       return 0;
        return int'(last);
    endfunction

    task automatic model_reset();
        m_v[1] = 0; m_v[2] = 0; m_v[3] = 0;
        m_lg = 1'b1;
        tag_q.delete();
        m_issues = 0;
        m_stalls = 0;
    endtask

    // One clock: apply inputs, check combinational outputs at negedge, advance model at posedge.
    task automatic cycle(input bit rst, input bit r0, input bit r1, input bit ordy);
        bit issue;
        rst_n          = rst;
        bus.req0_valid = r0;
        bus.req1_valid = r1;
        bus.out_ready  = ordy;
        @(negedge clk);
        go3     = !m_v[3] || ordy;
        go2     = !m_v[2] || go3;
        go1     = !m_v[1] || go2;
        m_grant = pick(r0, r1, m_lg);
        check("s3_en", int'(bus.s3_en), int'(go3));
        check("s2_en", int'(bus.s2_en), int'(go2));
        check("s1_en", int'(bus.s1_en), int'(go1));
        check("req0_ready", int'(bus.req0_ready), (go1 && m_grant == 0) ? 1 : 0);
        check("req1_ready", int'(bus.req1_ready), (go1 && m_grant == 1) ? 1 : 0);
        check("issue_sel", int'(bus.issue_sel), m_grant);
        check("out_valid", int'(bus.out_valid), (rst && m_v[3]) ? 1 : 0);
        check("busy", int'(bus.busy), (rst && (m_v[1] || m_v[2] || m_v[3])) ? 1 : 0);
        if (rst && m_v[3]) check("out_tag", int'(bus.out_tag), tag_q[0]);
`ifdef FMUL_CTRL_PERF_EN
        check("perf_issue", int'(perf_issue_cnt), m_issues);
        check("perf_stall", int'(perf_stall_cnt), m_stalls);
`endif
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            issue = (r0 || r1) && go1;
            if (m_v[3] && !ordy && m_stalls < SAT) m_stalls++;
            if (m_v[3] && ordy) void'(tag_q.pop_front());
            if (go3) m_v[3] = m_v[2];
            if (go2) m_v[2] = m_v[1];
            if (go1) m_v[1] = issue;
            if (issue) begin
                tag_q.push_back(m_grant);
                grant_log.push_back(m_grant);
                m_lg = m_grant[0];
                if (m_issues < SAT) m_issues++;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        grant_log.delete();
    endtask

    initial begin
        model_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b1;

        // Single req0 transaction: ready at N, product at N+3 only.
        do_reset(2);
        cycle(1, 1, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
        check("single_grants", grant_log.size(), 1);

        // Both requesters continuously for 4 cycles: grants alternate starting with req0.
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
        check("rr_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++) check("rr_grant", grant_log[i], i % 2);

        // Fill three entries, then stall the consumer for 5 cycles.
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0);
`ifdef FMUL_CTRL_PERF_EN
        check("stall_cnt_5", int'(perf_stall_cnt), 5);
`endif
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);

        // Stage-2 bubble collapses behind a stalled stage 3.
        do_reset(1);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

        // Reset with three entries in flight: nothing is delivered afterwards.
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);
        check("no_ghost", grant_log.size(), 3);

        // Twenty issues: counter saturates when narrow.
        do_reset(1);
        for (int i = 0; i < 20; i++) cycle(1, i[0], !i[0], 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        check("issue_total", grant_log.size(), 20);
`ifdef FMUL_CTRL_PERF_EN
        check("issue_sat", int'(perf_issue_cnt), 15);
`endif

        // Random traffic with occasional resets.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);
        check("drained", tag_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fmul_pipe_ctrl.md
FMUL_PIPE_CTRL -- requirements
Module: fmul_pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low; sampled on rising edge of clk.
REQ-004 req0_valid  input  1  requester 0 has a multiply operand pair ready.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req1_valid  input  1  requester 1 has a multiply operand pair ready.
REQ-007 req1_ready  output  1  requester 1 operands accepted this cycle.
REQ-008 issue_sel  output  1  operand mux select into stage 1 (0=req0, 1=req1); valid when s1_en is high and an issue occurs.
REQ-009 s1_en  output  1  load enable for stage-1 (operand/Booth) registers.
REQ-010 s2_en  output  1  load enable for stage-2 (partial-product/sign/exponent) registers.
REQ-011 s3_en  output  1  load enable for stage-3 (sum/normalise/round) registers.
REQ-012 out_valid  output  1  stage 3 holds a finished product.
REQ-013 out_tag  output  1  requester id of the stage-3 product.
REQ-014 out_ready  input  1  consumer accepts the product when out_valid is high.
REQ-015 busy  output  1  high when any stage holds a valid entry.
REQ-016 perf_issue_cnt, perf_stall_cnt  output  CNT_W each  present only under FMUL_CTRL_PERF_EN (REQ-034).

Function
REQ-017 The block SHALL track one valid bit (v1,v2,v3) and one tag bit (t1,t2,t3) per stage; no datapath bits are held.
REQ-018 Enables SHALL be: s3_en = !v3 | out_ready; s2_en = !v2 | s3_en; s1_en = !v1 | s2_en (combinational, bubble-collapsing).
REQ-019 On s3_en: v3<=v2, t3<=t2. On s2_en: v2<=v1, t2<=t1. On s1_en: v1<=issue, t1<=issue_sel.
REQ-020 out_valid SHALL equal v3; out_tag SHALL equal t3; busy = v1|v2|v3.
REQ-021 Arbitration SHALL be round-robin with a 1-bit last-grant register lg: only one valid -> that one; both valid -> requester !lg.
REQ-022 issue = (req0_valid|req1_valid) & s1_en; the granted requester's ready = s1_en, the other's ready = 0.
REQ-023 reqX_ready SHALL NOT depend on reqX_valid of the same requester except through grant selection; a lone valid requester sees ready = s1_en.
REQ-024 lg SHALL update to the granted id only on a cycle with issue; unchanged otherwise.
REQ-025 issue_sel SHALL equal the granted id when issue; when no request it SHALL hold lg.
REQ-026 Latency: operands accepted in cycle N produce out_valid in cycle N+3 with no back-pressure.
REQ-027 Throughput: one issue per cycle sustained while out_ready stays high.
REQ-028 Full pipeline (v1&v2&v3) with out_ready=0: all enables 0, both readies 0, state frozen.
REQ-029 Simultaneous out_ready and issue with full pipeline: all stages shift, new entry enters stage 1 same cycle.
REQ-030 Bubbles SHALL collapse: a stalled stage 3 does not block an empty stage 2 or 1 from filling.

Reset
REQ-031 With rst_n=0 at a rising edge: v1,v2,v3,t1,t2,t3 <= 0, lg <= 1 (req0 wins first contest), counters <= 0.
REQ-032 While rst_n=0: out_valid=0, busy=0; in-flight entries are discarded, none is delivered after reset release.
REQ-033 First rising edge after rst_n returns high SHALL accept a request (s1_en=1, empty pipeline).

Configuration
REQ-034 Macro FMUL_CTRL_PERF_EN defined: perf_issue_cnt increments on each issue; perf_stall_cnt increments each cycle v3 & !out_ready; both saturate at all-ones, clear only on reset.
REQ-035 FMUL_CTRL_PERF_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-036 Reset release, req0_valid=1 for one cycle N, out_ready=1 -> req0_ready=1 at N, out_valid=1 out_tag=0 at N+3 only.
REQ-037 req0_valid=req1_valid=1 continuously for 4 cycles after reset, out_ready=1 -> grants 0,1,0,1; out_tag sequence 0,1,0,1 from cycle 3.
REQ-038 Fill 3 entries, out_ready=0 for 5 cycles -> both readies 0, out_valid=1 held, tag stable; perf_stall_cnt=5 (PERF_EN).
REQ-039 Stage-2 bubble: issue, idle, issue, then out_ready=0 -> second entry advances to stage 2 while first holds in stage 3; s2_en=1, s3_en=0.
REQ-040 Assert rst_n=0 for one cycle with 3 entries in flight -> out_valid=0 next cycle and never rises without a new issue.
REQ-041 PERF_EN, CNT_W=4: 20 issues -> perf_issue_cnt saturates at 15.
